// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_pkg
// Description : Shared widths, opcode constants and phase encoding for the
//               RISC CPU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_pkg;

    localparam int ADDR_WIDTH   = 5;
    localparam int OPCODE_WIDTH = 3;

    localparam logic [OPCODE_WIDTH-1:0] HLT = 3'd0;
    localparam logic [OPCODE_WIDTH-1:0] SKZ = 3'd1;
    localparam logic [OPCODE_WIDTH-1:0] ADD = 3'd2;
    localparam logic [OPCODE_WIDTH-1:0] AND = 3'd3;
    localparam logic [OPCODE_WIDTH-1:0] XOR = 3'd4;
    localparam logic [OPCODE_WIDTH-1:0] LDA = 3'd5;
    localparam logic [OPCODE_WIDTH-1:0] STO = 3'd6;
    localparam logic [OPCODE_WIDTH-1:0] JMP = 3'd7;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

endpackage : risc_pkg
`default_nettype wire

// File: rtl/cpu_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_controller_if
// Description : Instruction/flag inputs and datapath strobes of the sequencer.
//               CTRL_RESUME_EN adds the resume input.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_controller_if #(
    parameter int OPCODE_WIDTH = risc_pkg::OPCODE_WIDTH
);
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    zero;
`ifdef CTRL_RESUME_EN
    logic                    resume;
`endif
    logic                    sel;
    logic                    rd;
    logic                    ld_ir;
    logic                    halt;
    logic                    inc_pc;
    logic                    ld_pc;
    logic                    ld_ac;
    logic                    wr;
    logic                    data_e;
    logic [2:0]              phase;

    modport master (
        output opcode, zero,
`ifdef CTRL_RESUME_EN
        output resume,
`endif
        input  sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e, phase
    );

    modport slave (
        input  opcode, zero,
`ifdef CTRL_RESUME_EN
        input  resume,
`endif
        output sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e, phase
    );
endinterface : cpu_controller_if
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Combinational phase/opcode/zero/halted to strobe decode.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import risc_pkg::*;
(
    input  phase_t                  i_phase,
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    input  logic                    i_zero,
    input  logic                    i_halted,
    output logic                    o_sel,
    output logic                    o_rd,
    output logic                    o_ld_ir,
    output logic                    o_halt,
    output logic                    o_inc_pc,
    output logic                    o_ld_pc,
    output logic                    o_ld_ac,
    output logic                    o_wr,
    output logic                    o_data_e
);

    logic w_aluop;
    logic w_is_skz;
    logic w_is_jmp;
    logic w_is_sto;

    assign w_aluop  = (i_opcode == ADD) || (i_opcode == AND) ||
                      (i_opcode == XOR) || (i_opcode == LDA);
    assign w_is_skz = (i_opcode == SKZ);
    assign w_is_jmp = (i_opcode == JMP);
    assign w_is_sto = (i_opcode == STO);

    always_comb begin
        o_sel    = 1'b0;
        o_rd     = 1'b0;
        o_ld_ir  = 1'b0;
        o_halt   = 1'b0;
        o_inc_pc = 1'b0;
        o_ld_pc  = 1'b0;
        o_ld_ac  = 1'b0;
        o_wr     = 1'b0;
        o_data_e = 1'b0;

        if (i_halted) begin
            o_halt = 1'b1;
        end else begin
            case (i_phase)
                INST_ADDR: begin
                    o_sel = 1'b1;
                end
                INST_FETCH: begin
                    o_sel = 1'b1;
                    o_rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    o_sel   = 1'b1;
                    o_rd    = 1'b1;
                    o_ld_ir = 1'b1;
                end
                // PC steps past every instruction here, including HLT.
                OP_ADDR: begin
                    o_inc_pc = 1'b1;
                    o_halt   = (i_opcode == HLT);
                end
                OP_FETCH: begin
                    o_rd = w_aluop;
                end
                ALU_OP: begin
                    o_rd     = w_aluop;
                    o_inc_pc = w_is_skz & i_zero;
                    o_ld_pc  = w_is_jmp;
                    o_data_e = w_is_sto;
                end
                STORE: begin
                    o_rd     = w_aluop;
                    o_ld_ac  = w_aluop;
                    o_ld_pc  = w_is_jmp;
                    o_wr     = w_is_sto;
                    o_data_e = w_is_sto;
                end
                default: begin
                    o_sel = 1'b0;
                end
            endcase
        end
    end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_controller
// Description : 8-phase instruction sequencer: phase register, halted flag and
//               strobe decode. CTRL_RESUME_EN enables leaving HALTED on resume.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_controller
    import risc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    cpu_controller_if.slave  bus
);

    phase_t r_phase;
    phase_t w_phase_nxt;
    logic   r_halted;
    logic   w_halted_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase  <= INST_ADDR;
            r_halted <= 1'b0;
        end else begin
            r_phase  <= w_phase_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // HALTED parks the phase at 3'b111 with the halted flag set.
    always_comb begin
        w_phase_nxt  = r_phase;
        w_halted_nxt = r_halted;
        if (r_halted) begin
`ifdef CTRL_RESUME_EN
            if (bus.resume) begin
                w_phase_nxt  = INST_ADDR;
                w_halted_nxt = 1'b0;
            end
`endif
        end else if ((r_phase == OP_ADDR) && (bus.opcode == HLT)) begin
            w_phase_nxt  = STORE;
            w_halted_nxt = 1'b1;
        end else begin
            w_phase_nxt = phase_t'(r_phase + 3'd1);
        end
    end

    ctrl_decode u_ctrl_decode (
        .i_phase  (r_phase),
        .i_opcode (bus.opcode),
        .i_zero   (bus.zero),
        .i_halted (r_halted),
        .o_sel    (bus.sel),
        .o_rd     (bus.rd),
        .o_ld_ir  (bus.ld_ir),
        .o_halt   (bus.halt),
        .o_inc_pc (bus.inc_pc),
        .o_ld_pc  (bus.ld_pc),
        .o_ld_ac  (bus.ld_ac),
        .o_wr     (bus.wr),
        .o_data_e (bus.data_e)
    );

    assign bus.phase = r_phase;

endmodule : cpu_controller
`default_nettype wire

// File: doc/cpu_controller.md
# cpu_controller

Sequencing state machine of the RISC CPU. It steps through an 8‑phase instruction cycle and generates every control strobe for the datapath. This includes the `inc_pc` and `ld_pc` strobes that drive `program_counter`, so the controller sits directly upstream of the PC. It consumes the opcode from the instruction register and the accumulator zero flag.

## Interface
- `OPCODE_WIDTH`, 3: width of the instruction opcode field.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active‑high reset.
- `opcode`  in  `OPCODE_WIDTH`  opcode from the instruction register; valid from phase IDLE onward.
- `zero`  in  1  accumulator‑zero flag from the ALU.
- `sel`  out  1  address mux select: 1 = PC, 0 = IR operand.
- `rd`  out  1  memory read enable.
- `ld_ir`  out  1  instruction register load.
- `halt`  out  1  CPU halted.
- `inc_pc`  out  1  program counter increment (to `program_counter`).
- `ld_pc`  out  1  program counter load (to `program_counter`).
- `ld_ac`  out  1  accumulator load.
- `wr`  out  1  memory write enable.
- `data_e`  out  1  accumulator drives the data bus.
- `phase`  out  3  current phase, for debug.

## Operation
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = ADD | AND | XOR | LDA.
- Phase register advances one step per clock: INST_ADDR(0) → INST_FETCH(1) → INST_LOAD(2) → IDLE(3) → OP_ADDR(4) → OP_FETCH(5) → ALU_OP(6) → STORE(7) → INST_ADDR.
- One non‑halting instruction takes exactly 8 cycles.
- Outputs are combinational Moore/Mealy decode of `phase`, `opcode` and `zero`. Strobes not listed for a phase are 0.
  - INST_ADDR: `sel`.
  - INST_FETCH: `sel`, `rd`.
  - INST_LOAD: `sel`, `rd`, `ld_ir`.
  - IDLE: `sel`, `rd`, `ld_ir`.
  - OP_ADDR: `inc_pc`; `halt` = (opcode==HLT).
  - OP_FETCH: `rd` = ALUOP.
  - ALU_OP: `rd` = ALUOP; `inc_pc` = (SKZ & zero); `ld_pc` = JMP; `data_e` = STO.
  - STORE: `rd` = ALUOP; `ld_ac` = ALUOP; `ld_pc` = JMP; `wr` = STO; `data_e` = STO.
- HALTED state (encoded 3'b111 with a separate halted flag): entered from OP_ADDR when opcode==HLT.
  - In HALTED: `halt` = 1, all other outputs 0.
  - HALTED is held until reset, or until resume (see Configuration).
- `ld_pc` and `inc_pc` are never both 1 in the same cycle.

## Timing
- Reset: phase = INST_ADDR, halted = 0. Outputs during and after reset: `sel` = 1, all others 0, `phase` = 0.
- Reset asserted mid‑instruction aborts it immediately. No `wr` or `ld_pc` may be produced while `rst` = 1.
- First rising edge after `rst` deasserts moves the phase to INST_FETCH.
- PC increments on the edge ending OP_ADDR, i.e. the 5th edge of an instruction.
- SKZ with `zero`=1 adds a second increment on the edge ending ALU_OP. `zero` is sampled in ALU_OP only.
- JMP holds `ld_pc` for 2 cycles (ALU_OP, STORE), so the PC loads on both edges with the same target.
- On HLT, `inc_pc` still fires in OP_ADDR. The PC therefore points past HLT, and `halt` rises in OP_ADDR and stays high.
- PC wrap‑around (0x1F → 0x00) is owned by `program_counter`. The controller is unaffected.

## Configuration
- `CTRL_RESUME_EN` defined:
  - Adds input port `resume` (1 bit).
  - In HALTED, `resume` = 1 at a rising edge clears the halted flag and sets phase = INST_ADDR. Fetch continues at the instruction after HLT.
  - `resume` is ignored outside HALTED.
- `CTRL_RESUME_EN` undefined: no `resume` port, and HALTED is exited only by `rst`.

## Structure
- Shared package `risc_pkg` holds:
  - `ADDR_WIDTH` (5), `OPCODE_WIDTH`.
  - Opcode constants HLT…JMP.
  - Phase encoding constants INST_ADDR…STORE.
- One sub‑module, `ctrl_decode`: purely combinational `phase`/`opcode`/`zero`/halted → strobe decode. The top level holds only the phase register and the halted flag.

## Test plan
- Reset held 3 cycles then released → `sel`=1, all others 0, `phase`=0 during reset; `phase` counts 0…7 and returns to 0 after 8 edges.
- ADD (opcode 2) → `rd`=1 in phases 5–7; `ld_ac`=1 only in phase 7; `inc_pc`=1 only in phase 4.
- SKZ (opcode 1): with `zero`=1 → `inc_pc` high in phases 4 and 6 (2 pulses); with `zero`=0 → 1 pulse.
- JMP (opcode 7) → `ld_pc`=1 in phases 6 and 7; `inc_pc`=0 in those phases; `wr`=0 throughout.
- STO (opcode 6) → `data_e`=1 in phases 6–7; `wr`=1 only in phase 7; `rd`=0 in phases 5–7.
- HLT (opcode 0) → `halt` rises in phase 4 and stays 1 for 20+ cycles with all other strobes 0. Then:
  - with `CTRL_RESUME_EN`, a 1‑cycle `resume` → `phase`=0, `halt`=0;
  - otherwise, only `rst` clears it.
  - Additionally, `rst` asserted in phase 7 of STO → `wr` drops the same cycle.
